// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared widths, default prescaler ratio, ramp direction type
//               and the bar-graph decode helper for the LED bar PWM.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

   localparam int PWM_BITS          = 5;
   localparam int LED_COUNT         = 8;
   localparam int LEVEL_BITS        = 8;
   localparam int PRESC_DIV_DEFAULT = 100;

   // Upper level bits select how many LEDs are fully lit.
   localparam int FULL_BITS = LEVEL_BITS - PWM_BITS;

   typedef enum logic [1:0] {
      RAMP_HOLD = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_dir_e;

   // One-LSB-per-period step direction from current level toward target.
   function automatic ramp_dir_e ramp_dir(input logic [LEVEL_BITS-1:0] cur,
                                          input logic [LEVEL_BITS-1:0] tgt);
      ramp_dir_e dir;
      dir = RAMP_HOLD;
      if (cur < tgt) begin
         dir = RAMP_UP;
      end else if (cur > tgt) begin
         dir = RAMP_DOWN;
      end
      return dir;
   endfunction

   // LEDs below the fill index are solid, the LED at the fill index is
   // dimmed by the fractional part, everything above is dark.
   function automatic logic [LED_COUNT-1:0] bar_decode(
      input logic [LEVEL_BITS-1:0] level,
      input logic [PWM_BITS-1:0]   pwm);
      logic [LED_COUNT-1:0] bar;
      logic [FULL_BITS-1:0] full;
      logic [PWM_BITS-1:0]  duty;
      bar  = '0;
      full = level[LEVEL_BITS-1:PWM_BITS];
      duty = level[PWM_BITS-1:0];
      for (int i = 0; i < LED_COUNT; i++) begin
         if (i < int'(full)) begin
            bar[i] = 1'b1;
         end else if (i == int'(full)) begin
            bar[i] = (pwm < duty);
         end
      end
      return bar;
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_bar_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : led_bar_pwm_if
// Description : Control/status bundle between the level source and the LED
//               bar PWM engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_bar_pwm_if
   import led_pkg::*;
();

   logic                  enable_i;
   logic [LEVEL_BITS-1:0] nivel_i;
   logic [LED_COUNT-1:0]  leds_o;
   logic                  fin_periodo_o;
   logic [LEVEL_BITS-1:0] nivel_act_o;

   // Level source side.
   modport master (
      output enable_i,
      output nivel_i,
      input  leds_o,
      input  fin_periodo_o,
      input  nivel_act_o
   );

   // PWM engine side.
   modport slave (
      input  enable_i,
      input  nivel_i,
      output leds_o,
      output fin_periodo_o,
      output nivel_act_o
   );

endinterface
`default_nettype wire

// File: rtl/led_bar_pwm_divisor_tick.sv
`default_nettype none
// ============================================================================
// Module      : divisor_tick
// Description : Free-running prescaler; one-cycle tick every DIV enabled clk
//               cycles. Disable clears and holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_tick
   import led_pkg::*;
#(
   parameter int DIV = PRESC_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   output logic tick_o
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick is gated by enable so a disable on the tick cycle wins.
   assign tick_o = enable_i && (cnt_q == LAST);

   // Next count: clear while disabled, wrap after the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_bar_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_bar_pwm
// Description : 8-LED bar graph with 32-step PWM on the partially lit LED and
//               a displayed level that ramps one LSB per PWM period toward
//               the requested level.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bar_pwm
   import led_pkg::*;
#(
   parameter int PRESC_DIV = PRESC_DIV_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   led_bar_pwm_if.slave bus
);

   logic                  tick;
   logic                  period_end;
   ramp_dir_e             dir;

   logic [PWM_BITS-1:0]   pwm_q;
   logic [PWM_BITS-1:0]   pwm_d;
   logic [LEVEL_BITS-1:0] nivel_q;
   logic [LEVEL_BITS-1:0] nivel_d;
   logic [LED_COUNT-1:0]  leds_q;
   logic [LED_COUNT-1:0]  leds_d;
   logic                  fin_q;
   logic                  fin_d;

   divisor_tick #(
      .DIV (PRESC_DIV)
   ) u_divisor_tick (
      .clk      (clk),
      .reset    (reset),
      .enable_i (bus.enable_i),
      .tick_o   (tick)
   );

   // The tick that wraps the PWM counter closes the period.
   assign period_end = tick && (pwm_q == {PWM_BITS{1'b1}});
   assign dir        = ramp_dir(nivel_q, bus.nivel_i);

   // Next-state for PWM counter, ramp register, period flag and bar output.
   always_comb begin
      pwm_d   = pwm_q;
      nivel_d = nivel_q;
      fin_d   = period_end;
      leds_d  = '0;

      if (!bus.enable_i) begin
         pwm_d = '0;
      end else if (tick) begin
         pwm_d = pwm_q + 1'b1;
      end

      // Target is sampled only on the wrapping tick; mid-period changes wait.
      if (period_end) begin
         case (dir)
            RAMP_UP:   nivel_d = nivel_q + 1'b1;
            RAMP_DOWN: nivel_d = nivel_q - 1'b1;
            default:   nivel_d = nivel_q;
         endcase
      end

      if (bus.enable_i) begin
         leds_d = bar_decode(nivel_q, pwm_q);
      end
   end

   // State registers, all cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_q   <= '0;
         nivel_q <= '0;
         leds_q  <= '0;
         fin_q   <= 1'b0;
      end else begin
         pwm_q   <= pwm_d;
         nivel_q <= nivel_d;
         leds_q  <= leds_d;
         fin_q   <= fin_d;
      end
   end

   assign bus.leds_o        = leds_q;
   assign bus.fin_periodo_o = fin_q;
   assign bus.nivel_act_o   = nivel_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_bar_pwm
// Description : Self-checking bench for led_bar_pwm with PRESC_DIV = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bar_pwm;

   localparam int DIV = 4;
   localparam int PER = 32 * DIV;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   led_bar_pwm_if bus ();

   led_bar_pwm #(
      .PRESC_DIV (DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the enabled-cycle count since (re)start gives the tick
   // phase and PWM step by division; period end is every PER-th cycle.
   int         m_n     = 0;
   int         m_level = 0;
   logic [7:0] m_leds  = '0;
   logic       m_fin   = 1'b0;

   function automatic logic [7:0] exp_bar(input int level, input int pwm);
      int full;
      int duty;
      int v;
      full = level / 32;
      duty = level % 32;
      v    = (1 << full) - 1;
      if (pwm < duty) v = v + (1 << full);
      return v[7:0];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_n = 0; m_level = 0; m_leds = '0; m_fin = 1'b0;
      end else if (!bus.enable_i) begin
         m_n = 0; m_leds = '0; m_fin = 1'b0;
      end else begin
         m_leds = exp_bar(m_level, (m_n / DIV) % 32);
         m_fin  = ((m_n + 1) % PER) == 0;
         if (m_fin) begin
            if (m_level < int'(bus.nivel_i))      m_level = m_level + 1;
            else if (m_level > int'(bus.nivel_i)) m_level = m_level - 1;
         end
         m_n = m_n + 1;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("leds_model", {24'd0, bus.leds_o}, {24'd0, m_leds});
      check("fin_model", {31'd0, bus.fin_periodo_o}, {31'd0, m_fin});
      check("nivel_act_model", {24'd0, bus.nivel_act_o}, m_level);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int fin_seen;
   int leds_or;
   int ok_cnt;
   int on_cnt;
   int k;
   bit done;

   initial begin
      reset        = 1'b1;
      bus.enable_i = 1'b0;
      bus.nivel_i  = 8'd0;
      step(2);
      check("reset_leds", {24'd0, bus.leds_o}, 0);
      check("reset_fin", {31'd0, bus.fin_periodo_o}, 0);
      check("reset_nivel", {24'd0, bus.nivel_act_o}, 0);

      // Level 0: dark bar, period pulse every PER cycles.
      reset        = 1'b0;
      bus.enable_i = 1'b1;
      fin_seen = 0; leds_or = 0;
      repeat (3 * PER) begin
         step(1);
         fin_seen += int'(bus.fin_periodo_o);
         leds_or  |= int'(bus.leds_o);
      end
      check("fin_count_lvl0", fin_seen, 3);
      check("leds_dark_lvl0", leds_or, 0);

      // Ramp up to 0x48.
      bus.nivel_i = 8'h48;
      step(72 * PER - 1);
      check("ramp_71", {24'd0, bus.nivel_act_o}, 71);
      step(1);
      check("ramp_72", {24'd0, bus.nivel_act_o}, 72);

      ok_cnt = 0; on_cnt = 0; leds_or = 0;
      repeat (PER) begin
         step(1);
         if (bus.leds_o[1:0] == 2'b11) ok_cnt++;
         on_cnt  += int'(bus.leds_o[2]);
         leds_or |= int'(bus.leds_o[7:3]);
      end
      check("lvl72_led01_steady", ok_cnt, PER);
      check("lvl72_led2_on", on_cnt, 8 * DIV);
      check("lvl72_upper_dark", leds_or, 0);

      // Ramp on to full scale.
      bus.nivel_i = 8'hFF;
      step(183 * PER);
      check("ramp_255", {24'd0, bus.nivel_act_o}, 255);
      ok_cnt = 0; on_cnt = 0;
      repeat (PER) begin
         step(1);
         if (bus.leds_o[6:0] == 7'h7F) ok_cnt++;
         if (!bus.leds_o[7]) on_cnt++;
      end
      check("lvl255_low7_steady", ok_cnt, PER);
      check("lvl255_led7_off", on_cnt, DIV);

      // Restart and settle at 100, then ramp down to 90.
      reset = 1'b1;
      bus.nivel_i = 8'd100;
      step(2);
      reset = 1'b0;
      step(100 * PER);
      check("ramp_100", {24'd0, bus.nivel_act_o}, 100);
      step(PER / 2);
      bus.nivel_i = 8'd90;
      step(PER / 2 - 1);
      check("hold_mid_period", {24'd0, bus.nivel_act_o}, 100);
      step(1);
      check("down_99", {24'd0, bus.nivel_act_o}, 99);
      step(9 * PER);
      check("down_90", {24'd0, bus.nivel_act_o}, 90);
      step(2 * PER);
      check("settled_90", {24'd0, bus.nivel_act_o}, 90);

      // Disable mid-period with LEDs lit.
      step(50);
      check("lit_before_drop", {31'd0, (bus.leds_o != 8'd0)}, 1);
      bus.enable_i = 1'b0;
      step(1);
      check("drop_leds", {24'd0, bus.leds_o}, 0);
      check("drop_nivel", {24'd0, bus.nivel_act_o}, 90);
      step(20);
      check("disabled_nivel", {24'd0, bus.nivel_act_o}, 90);
      bus.enable_i = 1'b1;
      k = 0; done = 1'b0;
      while (k < 300 && !done) begin
         step(1);
         k++;
         if (bus.fin_periodo_o) done = 1'b1;
      end
      check("reenable_first_fin", k, PER);

      // Asynchronous reset mid-ramp.
      bus.nivel_i = 8'd200;
      step(3 * PER + 40);
      check("ramp_93", {24'd0, bus.nivel_act_o}, 93);
      #1 reset = 1'b1;
      #1;
      check("async_leds", {24'd0, bus.leds_o}, 0);
      check("async_nivel", {24'd0, bus.nivel_act_o}, 0);
      check("async_fin", {31'd0, bus.fin_periodo_o}, 0);
      #1 reset = 1'b0;
      step(PER - 1);
      check("restart_0", {24'd0, bus.nivel_act_o}, 0);
      step(1);
      check("restart_1", {24'd0, bus.nivel_act_o}, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_bar_pwm.md
LED_BAR_PWM -- requirements
Module: led_bar_pwm

Interface
REQ-001 Parameter PRESC_DIV, default 100, SHALL set the clk cycles per PWM tick (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 enable_i  input  1  SHALL enable the display; 0 blanks the LEDs.
REQ-005 nivel_i  input  8  SHALL be the target level, taken from the 8-bit output of the LED register.
REQ-006 leds_o  output  8  SHALL drive the board LEDs as a bar graph (bit 0 = bottom LED).
REQ-007 fin_periodo_o  output  1  SHALL be a one-cycle pulse at each PWM period end.
REQ-008 nivel_act_o  output  8  SHALL report the level currently displayed.

Function
REQ-009 Prescaler SHALL count 0..PRESC_DIV-1 while enable_i=1 and assert internal tick for one cycle when the count equals PRESC_DIV-1, then wrap to 0.
REQ-010 5-bit pwm_cnt SHALL increment on each tick and wrap 31->0; one PWM period = 32 ticks.
REQ-011 fin_periodo_o SHALL be 1 for exactly the cycle after the tick that wraps pwm_cnt 31->0 (registered).
REQ-012 nivel_act SHALL change only at period end: +1 if nivel_act < nivel_i, -1 if nivel_act > nivel_i, hold if equal (ramp 1 LSB per period, no overshoot).
REQ-013 nivel_i changes mid-period SHALL have no effect until the next period end; the value sampled is the one present on the wrapping tick cycle.
REQ-014 Bar decode, with F = nivel_act[7:5] and D = nivel_act[4:0]: leds_o[i] = 1 for i < F; leds_o[F] = (pwm_cnt < D); leds_o[i] = 0 for i > F.
REQ-015 leds_o SHALL be registered: it reflects nivel_act/pwm_cnt with exactly 1 clk latency.
REQ-016 nivel_act=0 SHALL give leds_o=0 constantly; nivel_act=255 SHALL give leds_o[6:0]=1 and leds_o[7] on for 31 of 32 ticks.
REQ-017 enable_i=0 SHALL clear prescaler and pwm_cnt and hold them at 0, hold nivel_act, force leds_o=0 on the next clk, and suppress fin_periodo_o.
REQ-018 On enable_i 0->1, counting SHALL restart from prescaler=0, pwm_cnt=0; the first tick occurs PRESC_DIV cycles later.
REQ-019 When tick and enable_i falling edge coincide, the disable SHALL take priority: no pwm_cnt or nivel_act update.

Reset
REQ-020 Asserting reset SHALL immediately clear prescaler, pwm_cnt, nivel_act, leds_o, nivel_act_o and fin_periodo_o to 0, independent of clk.
REQ-021 After reset deassertion, operation SHALL resume per REQ-018 on the first clk edge; a reset mid-ramp SHALL restart the ramp from 0.

Structure
REQ-022 Shared package led_pkg SHALL hold PWM_BITS=5, LED_COUNT=8, LEVEL_BITS=8 and the default PRESC_DIV constant.
REQ-023 The prescaler SHALL be a separate sub-module divisor_tick (ports clk, reset, enable_i, tick_o; parameter DIV).
REQ-024 Top level SHALL contain the pwm counter, ramp register and bar decoder; no latches, no derived clocks.

Verification (PRESC_DIV=4)
REQ-025 Reset, enable_i=1, nivel_i=0 -> leds_o=0 at all times; fin_periodo_o pulses every 128 clk.
REQ-026 nivel_i=8'h48 from reset -> nivel_act_o steps +1 per period, reaching 72 after 72 periods; then LEDs 0,1 steady on and LED2 on 8 of 32 ticks.
REQ-027 nivel_act=255 settled -> leds_o[6:0]=7'h7F steady; leds_o[7] low only while pwm_cnt=31.
REQ-028 nivel_act=100 settled, nivel_i set to 90 mid-period -> no change until period end, then -1 per period down to 90.
REQ-029 enable_i dropped mid-period with LEDs lit -> leds_o=0 next clk, nivel_act held; re-enable -> first fin_periodo_o after 128 clk.
REQ-030 Asynchronous reset pulsed between clk edges mid-ramp -> all outputs 0 before next edge; ramp restarts from 0.
